// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - opcode and state types shared by the bit-serial sequencer.
package bs_pkg;

  typedef enum logic [2:0] {
    OP_NOP_WAIT = 3'b000,
    OP_NOP      = 3'b001,
    OP_MUL_YD   = 3'b010,
    OP_MUL_XND  = 3'b011,
    OP_ADD0     = 3'b100,
    OP_ADD1     = 3'b101,
    OP_WAIT_REL = 3'b110,
    OP_LOAD_X   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    DISPATCH,
    READ,
    SHIFT,
    MULT,
    ADD,
    LOAD
  } ctrl_state_e;

  function automatic logic is_mul(opcode_e op);
    return (op == OP_MUL_YD) || (op == OP_MUL_XND);
  endfunction

endpackage

// File: rtl/bs_bit_counter.sv
// rtl/bs_bit_counter.sv - bit counter that wraps to zero at a run-time terminal value.
module bs_bit_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] count_q, count_d;

  assign o_count = count_q;
  assign o_wrap  = (count_q == i_term);

  always_comb begin
    count_d = count_q;
    if (i_clr)
      count_d = '0;
    else if (i_en)
      count_d = o_wrap ? '0 : count_q + W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/bs_seq_ctrl.sv
// rtl/bs_seq_ctrl.sv - instruction dispatch FSM and per-bit strobe decode for the bit-serial datapath.
module bs_seq_ctrl
  import bs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACC_PRE     = 3,
  parameter int GPR_PRE_YD  = 2,
  parameter int GPR_PRE_XND = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [2:0]                i_instr,
  input  logic                      i_start,
  output logic [$clog2(DATA_W)-1:0] o_con_bitsel,
  output logic                      o_con_mux,
  output logic                      o_con_muxalu,
  output logic                      o_con_gpr_shift,
  output logic                      o_con_gpr_write,
  output logic                      o_con_acc_shift,
  output logic                      o_con_acc_write,
  output logic                      o_con_pcincr,
  output logic                      o_busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_PRE);
  localparam logic [CNT_W-1:0] GPR_YD_N  = CNT_W'(GPR_PRE_YD);
  localparam logic [CNT_W-1:0] GPR_XND_N = CNT_W'(GPR_PRE_XND);

  ctrl_state_e      state_q;
  opcode_e          op_q;
  opcode_e          instr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] gpr_pre;
  logic             cnt_wrap;
  logic             active;

  assign instr   = opcode_e'(i_instr);
  assign active  = i_en && i_rst_n;
  assign gpr_pre = (op_q == OP_MUL_XND) ? GPR_XND_N : GPR_YD_N;

  // SHIFT is the only phase that terminates on the pre-shift length rather than the word width.
  bs_bit_counter #(.W(CNT_W)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q == DISPATCH),
    .i_en    (i_en && (state_q != DISPATCH)),
    .i_term  ((state_q == SHIFT) ? ACC_LAST : DATA_LAST),
    .o_count (count),
    .o_wrap  (cnt_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DISPATCH;
      op_q    <= OP_NOP;
    end else if (i_en) begin
      case (state_q)
        DISPATCH: begin
          if (is_mul(instr)) begin
            op_q    <= instr;
            state_q <= READ;
          end else if ((instr == OP_ADD0) || (instr == OP_ADD1)) begin
            op_q    <= instr;
            state_q <= ADD;
          end else if (instr == OP_LOAD_X) begin
            op_q    <= instr;
            state_q <= LOAD;
          end
        end
        READ:            if (cnt_wrap) state_q <= SHIFT;
        SHIFT:           if (cnt_wrap) state_q <= MULT;
        MULT, ADD, LOAD: if (cnt_wrap) state_q <= DISPATCH;
        default:         state_q <= DISPATCH;
      endcase
    end
  end

  assign o_con_bitsel = count;
  assign o_busy       = (state_q != DISPATCH);

  always_comb begin
    o_con_mux       = 1'b0;
    o_con_muxalu    = 1'b0;
    o_con_gpr_shift = 1'b0;
    o_con_gpr_write = 1'b0;
    o_con_acc_shift = 1'b0;
    o_con_acc_write = 1'b0;
    o_con_pcincr    = 1'b0;
    if (active) begin
      case (state_q)
        DISPATCH: begin
          case (instr)
            OP_NOP_WAIT: o_con_pcincr = i_start;
            OP_NOP:      o_con_pcincr = 1'b1;
            OP_WAIT_REL: o_con_pcincr = !i_start;
            default:     o_con_pcincr = 1'b0;
          endcase
        end
        READ: begin
          o_con_muxalu    = 1'b1;
          o_con_gpr_shift = 1'b1;
          o_con_gpr_write = 1'b1;
          o_con_acc_shift = 1'b1;
          o_con_acc_write = 1'b1;
        end
        SHIFT: begin
          o_con_acc_shift = (count < ACC_LAST);
          o_con_gpr_shift = (count < gpr_pre);
        end
        MULT, ADD: begin
          o_con_gpr_shift = 1'b1;
          o_con_gpr_write = 1'b1;
          o_con_acc_shift = 1'b1;
          o_con_acc_write = (state_q == MULT) && (op_q == OP_MUL_XND);
          o_con_pcincr    = cnt_wrap;
        end
        LOAD: begin
          o_con_mux       = 1'b1;
          o_con_gpr_shift = 1'b1;
          o_con_gpr_write = 1'b1;
          o_con_pcincr    = cnt_wrap;
        end
        default: o_con_pcincr = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_seq_ctrl.sv
// tb/tb_bs_seq_ctrl.sv - scoreboard bench for bs_seq_ctrl at DATA_W=8 and DATA_W=5.
module tb_bs_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [2:0] instr = 3'b001;
  logic [2:0] instr5 = 3'b001;

  logic [2:0] bitsel, bitsel5;
  logic mux, muxalu, gs, gw, acs, acw, pc, busy;
  logic mux5, muxalu5, gs5, gw5, acs5, acw5, pc5, busy5;

  typedef struct packed {
    logic [2:0] bitsel;
    logic mux, muxalu, gs, gw, acs, acw, pc, busy;
  } vec_t;

  typedef struct packed {
    logic       en;
    logic [2:0] instr;
    logic       start;
  } stim_t;

  vec_t  obs, obs5;
  stim_t sq[$];
  vec_t  eq[$];
  int    n_vec = 0;
  int    n_fail = 0;

  assign obs  = {bitsel, mux, muxalu, gs, gw, acs, acw, pc, busy};
  assign obs5 = {bitsel5, mux5, muxalu5, gs5, gw5, acs5, acw5, pc5, busy5};

  always #5 clk = ~clk;

  bs_seq_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_instr(instr), .i_start(start),
    .o_con_bitsel(bitsel), .o_con_mux(mux), .o_con_muxalu(muxalu),
    .o_con_gpr_shift(gs), .o_con_gpr_write(gw), .o_con_acc_shift(acs),
    .o_con_acc_write(acw), .o_con_pcincr(pc), .o_busy(busy)
  );

  bs_seq_ctrl #(.DATA_W(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_instr(instr5), .i_start(start),
    .o_con_bitsel(bitsel5), .o_con_mux(mux5), .o_con_muxalu(muxalu5),
    .o_con_gpr_shift(gs5), .o_con_gpr_write(gw5), .o_con_acc_shift(acs5),
    .o_con_acc_write(acw5), .o_con_pcincr(pc5), .o_busy(busy5)
  );

  function automatic vec_t mk(int b, bit mx, bit ma, bit g_s, bit g_w, bit a_s, bit a_w, bit p, bit bz);
    vec_t v;
    v.bitsel = 3'(b);
    v.mux = mx; v.muxalu = ma; v.gs = g_s; v.gw = g_w;
    v.acs = a_s; v.acw = a_w; v.pc = p; v.busy = bz;
    return v;
  endfunction

  function automatic logic [2:0] rnd_op();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic add(bit e, logic [2:0] op, bit st, vec_t v);
    stim_t s;
    s.en = e; s.instr = op; s.start = st;
    sq.push_back(s);
    eq.push_back(v);
  endtask

  // Expected multiply: dispatch, READ dw, SHIFT ACC_PRE+1 (=4), MULT dw.
  task automatic push_mul(logic [2:0] op, int dw);
    bit xnd = (op == 3'b011);
    int gpre = xnd ? 1 : 2;
    add(1, op, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < dw; k++) add(1, rnd_op(), 1'($urandom_range(0, 1)), mk(k, 0, 1, 1, 1, 1, 1, 0, 1));
    for (int k = 0; k < 4; k++)  add(1, rnd_op(), 1'($urandom_range(0, 1)), mk(k, 0, 0, k < gpre, 0, k < 3, 0, 0, 1));
    for (int k = 0; k < dw; k++) add(1, rnd_op(), 1'($urandom_range(0, 1)), mk(k, 0, 0, 1, 1, 1, xnd, k == dw - 1, 1));
  endtask

  task automatic push_load(int dw, int stall_k, int nstall);
    add(1, 3'b111, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < dw; k++) begin
      if (k == stall_k)
        for (int j = 0; j < nstall; j++) add(0, rnd_op(), 1'($urandom_range(0, 1)), mk(k, 0, 0, 0, 0, 0, 0, 0, 1));
      add(1, rnd_op(), 1'($urandom_range(0, 1)), mk(k, 1, 0, 1, 1, 0, 0, k == dw - 1, 1));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; instr = 3'b001; instr5 = 3'b001; start = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_state dut8: got %h want 0", obs); end
    n_vec++;
    if (obs5 !== '0) begin n_fail++; $display("FAIL reset_state dut5: got %h want 0", obs5); end
    @(negedge clk);
    rst_n = 1'b1; instr = 3'b000; start = 1'b0;
  endtask

  task automatic test_mul(logic [2:0] op);
    push_mul(op, 8);
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL mul op=%b cyc %0d: got %h want %h", op, i + 1, obs, e); end
    end
  endtask

  task automatic test_stall();
    add(0, 3'b001, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 3'b000, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    push_load(8, 4, 3);
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL load_stall cyc %0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_wait();
    vec_t z, p;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    p = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 3'b000, 0, z);
    add(1, 3'b000, 1, p);
    for (int k = 0; k < 3; k++) add(1, 3'b110, 1, z);
    add(1, 3'b110, 0, p);
    for (int k = 0; k < 3; k++) add(1, 3'b001, 1'($urandom_range(0, 1)), p);
    add(0, 3'b001, 0, z);
    add(0, 3'b110, 0, z);
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL wait_nop cyc %0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 2; a++) begin
      add(1, (a == 0) ? 3'b100 : 3'b101, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) add(1, 3'b111, 1'($urandom_range(0, 1)), mk(k, 0, 0, 1, 1, 1, 0, k == 7, 1));
    end
    push_load(8, -1, 0);
    push_mul(3'b011, 8);
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL add_b2b cyc %0d: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_width5();
    instr = 3'b000;
    push_load(5, 2, 2);
    push_mul(3'b011, 5);
    push_mul(3'b010, 5);
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr5 = s.instr; start = s.start; #1;
      n_vec++;
      if (obs5 !== e) begin n_fail++; $display("FAIL width5 cyc %0d: got %h want %h", i, obs5, e); end
    end
    instr5 = 3'b001;
  endtask

  task automatic test_reset_mid();
    push_mul(3'b010, 8);
    while (eq.size() > 18) begin
      void'(sq.pop_back());
      void'(eq.pop_back());
    end
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL pre_reset cyc %0d: got %h want %h", i, obs, e); end
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs !== mk(5, 0, 0, 1, 1, 1, 0, 0, 1)) begin n_fail++; $display("FAIL mult_cnt5: got %h want %h", obs, mk(5, 0, 0, 1, 1, 1, 0, 0, 1)); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; instr = 3'b000; start = 1'b0;
    for (int k = 0; k < 3; k++) add(1, 3'b000, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; sq.size() > 0; i++) begin
      stim_t s; vec_t e;
      s = sq.pop_front(); e = eq.pop_front();
      @(negedge clk); en = s.en; instr = s.instr; start = s.start; #1;
      n_vec++;
      if (obs !== e) begin n_fail++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_mul(3'b010);
    test_mul(3'b011);
    test_stall();
    test_wait();
    test_back_to_back();
    test_width5();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
